rr_mux: RTL and testbench

Parametrised N-channel, W-bit arbitrated multiplexer with a valid/ready handshake on every input and on the output. It generalises the 4-bit, 4-input combinational select. Channel choice comes from an internal arbiter (fixed-priority or round-robin, chosen at run time) instead of an external select. The winning word is captured in a registered output stage. The block sits wherever several producers share one downstream consumer.

---
 rtl/rr_mux_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 29 ++
 rtl/rr_mux.sv | 108 ++++++++++
 tb/tb_rr_mux.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared types and helpers for the arbitrated multiplexer.
//   arb_mode_e      - arbitration mode (fixed priority / round-robin)
//   first_set_from  - wrap-around priority search over a request vector
package rr_mux_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Widest request vector the search helper handles.
    localparam int RR_MAX_N = 32;
    localparam int RR_IDXW  = $clog2(RR_MAX_N);

    // Returns the index of the first set bit of req[n-1:0], scanning
    // start, start+1, ... modulo n. Returns -1 when no bit is set.
    function automatic int first_set_from(input logic [RR_MAX_N-1:0] req,
                                          input int                  start,
                                          input int                  n);
        int                 win;
        logic [RR_IDXW-1:0] idx;
        win = -1;
        for (int k = 0; k < RR_MAX_N; k++) begin
            if (k < n) begin
                idx = RR_IDXW'((start + k) % n);
                if (win < 0 && req[idx]) begin
                    win = int'(idx);
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational N-way arbiter.
//   req   in  N     per-channel requests
//   mode  in  1     ARB_FIXED: lowest index wins; ARB_RR: search from start
//   start in  SELW  first index examined in round-robin mode
//   grant out N     one-hot grant, or zero when nothing requests
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]                          req,
    input  arb_mode_e                             mode,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0]  start,
    output logic [N-1:0]                          grant
);

    int win;

    always_comb begin
        win   = first_set_from(RR_MAX_N'(req), (mode == ARB_RR) ? int'(start) : 0, N);
        grant = '0;
        for (int i = 0; i < N; i++) begin
            if (win == i) begin
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux.sv
// rr_mux: N-channel, W-bit arbitrated multiplexer with a registered output.
//   clk       in  1     clock
//   reset_n   in  1     asynchronous active-low reset
//   mode      in  1     0 = fixed priority, 1 = round-robin
//   in_valid  in  N     per-channel request
//   in_data   in  N*W   channel i at [i*W +: W]
//   in_ready  out N     per-channel accept (at most one high)
//   out_valid out 1     output register holds a word
//   out_data  out W     registered selected word
//   out_sel   out SELW  channel that supplied out_data
//   out_ready in  1     consumer accepts the output word
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            mode,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_sel,
    input  logic            out_ready
);

    localparam logic [SELW-1:0] LAST_IDX = SELW'(N - 1);

    arb_mode_e       mode_e;
    logic [N-1:0]    grant;
    logic [SELW-1:0] start;
    logic [SELW-1:0] win_sel;
    logic [W-1:0]    win_data;
    logic            load;
    logic            xfer;

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0] out_sel_q,   out_sel_d;
    logic [SELW-1:0] last_q,      last_d;

    assign mode_e = arb_mode_e'(mode);

    // Round-robin search begins just past the last winner, wrapping at N-1.
    assign start = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;

    rr_arbiter #(.N(N)) u_arb (
        .req   (in_valid),
        .mode  (mode_e),
        .start (start),
        .grant (grant)
    );

    always_comb begin
        win_sel  = '0;
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                win_sel  = SELW'(i);
                win_data = in_data[i*W +: W];
            end
        end
    end

    assign load = !out_valid_q || out_ready;
    assign xfer = load && (|grant);

    // Gated by reset_n so no producer sees an accept while the block is held in reset.
    assign in_ready = reset_n ? (grant & {N{load}}) : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        last_d      = last_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = win_data;
            out_sel_d   = win_sel;
            last_d      = win_sel;
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            last_q      <= LAST_IDX;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux.sv
module tb_rr_mux;

    localparam int N    = 4;
    localparam int W    = 4;
    localparam int SELW = 2;

    logic            clk;
    logic            reset_n;
    logic            mode;
    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_sel;
    logic            out_ready;

    int checks;
    int errors;

    logic [W-1:0] dval [N];

    rr_mux #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        mode      = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_in_ready got %b want 0000", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_sel !== 2'd0) begin
            errors++; $display("FAIL reset_outputs got v=%b d=%h s=%0d want v=0 d=0 s=0",
                               out_valid, out_data, out_sel);
        end
        in_valid = 4'b0000;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        in_valid = 4'b0010;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'h5 || out_sel !== 2'd1) begin
            errors++; $display("FAIL reset_setup got v=%b d=%h s=%0d want v=1 d=5 s=1",
                               out_valid, out_data, out_sel);
        end
        in_valid = 4'b0000;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_sel !== 2'd0 || in_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_async got v=%b d=%h s=%0d r=%b want v=0 d=0 s=0 r=0000",
                               out_valid, out_data, out_sel, in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        mode      = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_valid = 4'b0001 << i;
            #1;
            checks++;
            if (in_ready !== (4'b0001 << i)) begin
                errors++; $display("FAIL single_ready ch%0d got %b want %b", i, in_ready, 4'b0001 << i);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== dval[i] || out_sel !== SELW'(i)) begin
                errors++; $display("FAIL single_out ch%0d got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                                   i, out_valid, out_data, out_sel, dval[i], i);
            end
        end
    endtask

    task automatic test_fixed();
        mode      = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0001) begin
                errors++; $display("FAIL fixed_ready cyc%0d got %b want 0001", c, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 4'h0 || out_sel !== 2'd0) begin
                errors++; $display("FAIL fixed_out cyc%0d got v=%b d=%h s=%0d want v=1 d=0 s=0",
                                   c, out_valid, out_data, out_sel);
            end
        end
    endtask

    task automatic test_rr_wrap();
        logic [SELW-1:0] exp_sel [6];
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        // Fresh reset so the pointer starts at N-1.
        in_valid = 4'b0000;
        reset_n  = 1'b0;
        #2;
        reset_n  = 1'b1;
        step();
        mode      = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (in_ready !== (4'b0001 << exp_sel[c])) begin
                errors++; $display("FAIL rr_ready cyc%0d got %b want %b", c, in_ready, 4'b0001 << exp_sel[c]);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_sel !== exp_sel[c] || out_data !== dval[exp_sel[c]]) begin
                errors++; $display("FAIL rr_out cyc%0d got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                                   c, out_valid, out_data, out_sel, dval[exp_sel[c]], exp_sel[c]);
            end
        end
    endtask

    // Entered with channel 1 held in the output register (last = 1).
    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        mode      = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_ready cyc%0d got %b want 0000", c, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 4'h5 || out_sel !== 2'd1) begin
                errors++; $display("FAIL bp_hold cyc%0d got v=%b d=%h s=%0d want v=1 d=5 s=1",
                                   c, out_valid, out_data, out_sel);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++; $display("FAIL bp_release_ready got %b want 0100", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hA || out_sel !== 2'd2) begin
            errors++; $display("FAIL bp_release_out got v=%b d=%h s=%0d want v=1 d=a s=2",
                               out_valid, out_data, out_sel);
        end
    endtask

    // Entered with last = 2.
    task automatic test_mode_switch();
        out_ready = 1'b1;
        in_valid  = 4'b1010;
        mode      = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++; $display("FAIL ms_fixed_ready got %b want 0010", in_ready);
        end
        step();
        checks++;
        if (out_sel !== 2'd1 || out_data !== 4'h5) begin
            errors++; $display("FAIL ms_fixed_out got d=%h s=%0d want d=5 s=1", out_data, out_sel);
        end
        mode = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++; $display("FAIL ms_rr_ready got %b want 1000", in_ready);
        end
        step();
        checks++;
        if (out_sel !== 2'd3 || out_data !== 4'hF) begin
            errors++; $display("FAIL ms_rr_out got d=%h s=%0d want d=f s=3", out_data, out_sel);
        end
    endtask

    // Entered with last = 3: lone channel equal to last is re-granted; then idle drains.
    task automatic test_regrant_idle();
        mode      = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b1000;
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++; $display("FAIL regrant_ready got %b want 1000", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== 4'hF) begin
            errors++; $display("FAIL regrant_out got v=%b d=%h s=%0d want v=1 d=f s=3",
                               out_valid, out_data, out_sel);
        end
        in_valid = 4'b0000;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_sel !== 2'd3 || out_data !== 4'hF) begin
            errors++; $display("FAIL idle_hold got v=%b d=%h s=%0d want v=0 d=f s=3",
                               out_valid, out_data, out_sel);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        dval[0] = 4'h0;
        dval[1] = 4'h5;
        dval[2] = 4'hA;
        dval[3] = 4'hF;
        in_data = {dval[3], dval[2], dval[1], dval[0]};

        test_reset();
        test_single();
        test_fixed();
        test_rr_wrap();
        test_backpressure();
        test_mode_switch();
        test_regrant_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
